sub_mult_abs_sequencer: RTL and testbench
=========================================

// Module: sub_mult_abs_sequencer
// PURPOSE
//  Feeds the three input streams of the abs((x-grid)*scale) datapath. Each accepted input sample x
//  is replayed as one frame of GRID_POINTS beats: x on the data stream, grid[i] from a local
//  table on the grid stream, and the shared scale on the scale stream. The three frames always
//  have equal length and aligned tlast, so the datapath never pads. Sits between the feature
//  source and the datapath; the grid table and scale are loaded through a simple config port.
// PARAMETERS
//  DATA_WIDTH_DATA        16   width of x and grid words (signed fixed point)
//  FRACTIONAL_BITS_SCALE  12   fractional bits of scale; reset scale = 1<<FRACTIONAL_BITS_SCALE
//  DATA_WIDTH_SCALE       16   width of scale word
//  GRID_POINTS            8    beats per frame (>=2)
//  ADDR_WIDTH   $clog2(GRID_POINTS)  grid table index width
// PORTS
//  clk                  in   1                 clock
//  rst                  in   1                 synchronous reset, active high
//  cfg_grid_we          in   1                 write grid[cfg_grid_addr] = cfg_grid_data
//  cfg_grid_addr        in   ADDR_WIDTH        grid table index
//  cfg_grid_data        in   DATA_WIDTH_DATA   grid value
//  cfg_scale_we         in   1                 write scale = cfg_scale_data
//  cfg_scale_data       in   DATA_WIDTH_SCALE  scale value
//  cfg_err              out  1                 1-cycle pulse: config write rejected
//  busy                 out  1                 1 while a frame is in progress
//  s_axis_x_tdata       in   DATA_WIDTH_DATA   input sample x
//  s_axis_x_tvalid/tready/tlast  in/out/in  1  input handshake; tlast marks last feature
//  m_axis_data_tdata/tvalid/tready/tlast/tuser  out/out/in/out/out  DATA_WIDTH_DATA/1/1/1/1  x stream
//  m_axis_grid_tdata/tvalid/tready/tlast   out/out/in/out  DATA_WIDTH_DATA/1/1/1  grid stream
//  m_axis_scale_tdata/tvalid/tready/tlast  out/out/in/out  DATA_WIDTH_SCALE/1/1/1  scale stream
// BEHAVIOUR
//  - Reset: state IDLE, idx=0, sent[2:0]=0, all m_*_tvalid=0, tdata/tlast/tuser=0, busy=0,
//    cfg_err=0, s_axis_x_tready=1 after reset deasserts, grid table cleared to 0, scale=1.0.
//  - IDLE: s_axis_x_tready=1. On s_tvalid&s_tready: latch x and s_tlast, idx<=0, sent<=0, go RUN.
//  - RUN: s_axis_x_tready=0, busy=1. Output k has tvalid = ~sent[k]; tdata = x / grid[idx] / scale;
//    all three tlast = (idx==GRID_POINTS-1); m_axis_data_tuser = latched s_tlast on all beats.
//  - sent[k] sets on tvalid&tready of stream k. Beat done when every stream is sent or handshaking
//    this cycle. On beat done: idx==GRID_POINTS-1 -> IDLE; else idx<=idx+1, sent<=0.
//  - tvalid never depends on tready; a stream whose ready is low holds its tvalid and tdata stable.
//  - Latency: first beat valid the cycle after x is accepted. All readies high: 1 beat/cycle,
//    GRID_POINTS+1 cycles per sample (one IDLE cycle between frames).
//  - Config writes take effect next cycle, accepted only in IDLE. A write in RUN (or the cycle
//    x is accepted) is dropped and cfg_err pulses for one cycle; the table never changes mid-frame.
//    Simultaneous grid and scale writes are both applied (or both rejected).
//  - Reset mid-frame: frame abandoned, outputs drop tvalid the cycle after rst, no partial tlast.
//  - Data passes unmodified; no arithmetic on x, grid, or scale.
// TESTING
//  1 Load grid={0..7}<<12, scale=0x2000; send x=0x3000, all readies 1 -> 8 beats on each stream,
//    grid tdata 0x0000..0x7000, x constant 0x3000, scale 0x2000, tlast only on beat 7, 9 cycles.
//  2 Same, grid_tready low for beats 2-4 -> data/scale hold beat 2 (sent) with tvalid low until the
//    grid stream catches up; beat order and values unchanged, no beat duplicated or lost.
//  3 Random independent ready throttling on all three streams, 100 samples -> per-stream beat count
//    = 800, tlast count = 100, grid index sequence 0..7 repeated.
//  4 cfg_grid_we during RUN at beat 3 -> cfg_err pulses once, table unchanged; the same write in
//    IDLE -> applied, no cfg_err, the next frame uses the new value.
//  5 s_tlast=1 on x -> m_axis_data_tuser=1 on all 8 beats of that frame, 0 on the next frame.
//  6 Assert rst at beat 4 -> all tvalid 0 next cycle, table zero, scale 0x1000, tready 1 afterwards.

Source files
------------

// File: rtl/sub_mult_abs_sequencer.sv
// Replays each accepted sample x as a GRID_POINTS-beat frame on three aligned AXI-Stream outputs
// (x, grid[i], scale); the grid table and scale are loaded through a config port while idle.
module sub_mult_abs_sequencer #(
   parameter int DATA_WIDTH_DATA       = 16,
   parameter int FRACTIONAL_BITS_SCALE = 12,
   parameter int DATA_WIDTH_SCALE      = 16,
   parameter int GRID_POINTS           = 8,
   parameter int ADDR_WIDTH            = $clog2(GRID_POINTS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cfg_grid_we,
   input  logic [ADDR_WIDTH-1:0]       cfg_grid_addr,
   input  logic [DATA_WIDTH_DATA-1:0]  cfg_grid_data,
   input  logic                        cfg_scale_we,
   input  logic [DATA_WIDTH_SCALE-1:0] cfg_scale_data,
   output logic                        cfg_err,
   output logic                        busy,
   input  logic [DATA_WIDTH_DATA-1:0]  s_axis_x_tdata,
   input  logic                        s_axis_x_tvalid,
   output logic                        s_axis_x_tready,
   input  logic                        s_axis_x_tlast,
   output logic [DATA_WIDTH_DATA-1:0]  m_axis_data_tdata,
   output logic                        m_axis_data_tvalid,
   input  logic                        m_axis_data_tready,
   output logic                        m_axis_data_tlast,
   output logic                        m_axis_data_tuser,
   output logic [DATA_WIDTH_DATA-1:0]  m_axis_grid_tdata,
   output logic                        m_axis_grid_tvalid,
   input  logic                        m_axis_grid_tready,
   output logic                        m_axis_grid_tlast,
   output logic [DATA_WIDTH_SCALE-1:0] m_axis_scale_tdata,
   output logic                        m_axis_scale_tvalid,
   input  logic                        m_axis_scale_tready,
   output logic                        m_axis_scale_tlast
);

   localparam int unsigned TABLE_DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(GRID_POINTS - 1);
   localparam logic [DATA_WIDTH_SCALE-1:0] SCALE_ONE = DATA_WIDTH_SCALE'(1) << FRACTIONAL_BITS_SCALE;

   typedef enum logic {IDLE, RUN} state_t;

   state_t                      state, state_next;
   logic [ADDR_WIDTH-1:0]       idx, idx_next;
   logic [2:0]                  sent, sent_next;
   logic [DATA_WIDTH_DATA-1:0]  x_reg;
   logic                        x_last;
   logic [DATA_WIDTH_DATA-1:0]  grid_tbl [TABLE_DEPTH];
   logic [DATA_WIDTH_SCALE-1:0] scale_reg;
   logic                        x_accept;
   logic                        cfg_any;
   logic                        cfg_ok;
   logic [2:0]                  valid;
   logic [2:0]                  ready;
   logic [2:0]                  hs;
   logic                        beat_done;
   logic                        last_beat;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         sent  <= '0;
      end else begin
         state <= state_next;
         idx   <= idx_next;
         sent  <= sent_next;
      end
   end

   always_comb begin
      state_next          = state;
      idx_next            = idx;
      sent_next           = sent;
      s_axis_x_tready     = 1'b0;
      busy                = 1'b0;
      x_accept            = 1'b0;
      valid               = '0;
      hs                  = '0;
      beat_done           = 1'b0;
      last_beat           = 1'b0;
      ready               = {m_axis_scale_tready, m_axis_grid_tready, m_axis_data_tready};
      m_axis_data_tdata   = '0;
      m_axis_grid_tdata   = '0;
      m_axis_scale_tdata  = '0;
      m_axis_data_tuser   = 1'b0;
      case (state)
         IDLE: begin
            s_axis_x_tready = !rst;
            x_accept        = s_axis_x_tvalid && !rst;
            if (x_accept) begin
               state_next = RUN;
               idx_next   = '0;
               sent_next  = '0;
            end
         end
         RUN: begin
            busy               = 1'b1;
            // a stream that already handshook this beat waits for the others
            valid              = ~sent;
            hs                 = valid & ready;
            beat_done          = &(sent | hs);
            sent_next          = sent | hs;
            last_beat          = (idx == LAST_IDX);
            m_axis_data_tdata  = x_reg;
            m_axis_grid_tdata  = grid_tbl[idx];
            m_axis_scale_tdata = scale_reg;
            m_axis_data_tuser  = x_last;
            if (beat_done) begin
               if (last_beat) begin
                  state_next = IDLE;
               end else begin
                  idx_next  = idx + 1'b1;
                  sent_next = '0;
               end
            end
         end
      endcase
   end

   assign m_axis_data_tvalid  = valid[0];
   assign m_axis_grid_tvalid  = valid[1];
   assign m_axis_scale_tvalid = valid[2];
   assign m_axis_data_tlast   = last_beat;
   assign m_axis_grid_tlast   = last_beat;
   assign m_axis_scale_tlast  = last_beat;

   assign cfg_any = cfg_grid_we || cfg_scale_we;
   assign cfg_ok  = cfg_any && (state == IDLE) && !x_accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         x_reg     <= '0;
         x_last    <= 1'b0;
         scale_reg <= SCALE_ONE;
         cfg_err   <= 1'b0;
         for (int unsigned i = 0; i < TABLE_DEPTH; i++) begin
            grid_tbl[i] <= '0;
         end
      end else begin
         cfg_err <= cfg_any && !cfg_ok;
         if (x_accept) begin
            x_reg  <= s_axis_x_tdata;
            x_last <= s_axis_x_tlast;
         end
         if (cfg_ok && cfg_grid_we) begin
            grid_tbl[cfg_grid_addr] <= cfg_grid_data;
         end
         if (cfg_ok && cfg_scale_we) begin
            scale_reg <= cfg_scale_data;
         end
      end
   end

endmodule

// File: tb/tb_sub_mult_abs_sequencer.sv
// Bench for sub_mult_abs_sequencer: frame-level reference model plus table-driven and scripted cases.
module tb_sub_mult_abs_sequencer;

   localparam int GP = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_grid_we;
   logic [2:0]  cfg_grid_addr;
   logic [15:0] cfg_grid_data;
   logic        cfg_scale_we;
   logic [15:0] cfg_scale_data;
   logic        cfg_err;
   logic        busy;
   logic [15:0] s_axis_x_tdata;
   logic        s_axis_x_tvalid;
   logic        s_axis_x_tready;
   logic        s_axis_x_tlast;
   logic [15:0] m_axis_data_tdata;
   logic        m_axis_data_tvalid;
   logic        m_axis_data_tready;
   logic        m_axis_data_tlast;
   logic        m_axis_data_tuser;
   logic [15:0] m_axis_grid_tdata;
   logic        m_axis_grid_tvalid;
   logic        m_axis_grid_tready;
   logic        m_axis_grid_tlast;
   logic [15:0] m_axis_scale_tdata;
   logic        m_axis_scale_tvalid;
   logic        m_axis_scale_tready;
   logic        m_axis_scale_tlast;

   sub_mult_abs_sequencer #(
      .DATA_WIDTH_DATA(16), .FRACTIONAL_BITS_SCALE(12), .DATA_WIDTH_SCALE(16), .GRID_POINTS(GP)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_grid_we(cfg_grid_we), .cfg_grid_addr(cfg_grid_addr), .cfg_grid_data(cfg_grid_data),
      .cfg_scale_we(cfg_scale_we), .cfg_scale_data(cfg_scale_data),
      .cfg_err(cfg_err), .busy(busy),
      .s_axis_x_tdata(s_axis_x_tdata), .s_axis_x_tvalid(s_axis_x_tvalid),
      .s_axis_x_tready(s_axis_x_tready), .s_axis_x_tlast(s_axis_x_tlast),
      .m_axis_data_tdata(m_axis_data_tdata), .m_axis_data_tvalid(m_axis_data_tvalid),
      .m_axis_data_tready(m_axis_data_tready), .m_axis_data_tlast(m_axis_data_tlast),
      .m_axis_data_tuser(m_axis_data_tuser),
      .m_axis_grid_tdata(m_axis_grid_tdata), .m_axis_grid_tvalid(m_axis_grid_tvalid),
      .m_axis_grid_tready(m_axis_grid_tready), .m_axis_grid_tlast(m_axis_grid_tlast),
      .m_axis_scale_tdata(m_axis_scale_tdata), .m_axis_scale_tvalid(m_axis_scale_tvalid),
      .m_axis_scale_tready(m_axis_scale_tready), .m_axis_scale_tlast(m_axis_scale_tlast)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0]          x;
      logic                 user;
      logic [15:0]          scale;
      logic [GP-1:0][15:0]  grid;
   } frame_t;

   typedef struct {
      logic        valid;
      logic [15:0] grid;
      logic        last;
      logic        busy;
      logic        sready;
   } vec_t;

   int unsigned         checks = 0;
   int unsigned         errors = 0;
   frame_t              frames[$];
   int                  cnt[3];
   int                  tot_beats[3];
   int                  tot_last[3];
   logic [2:0]          pend;
   logic [2:0][15:0]    pend_d;
   logic [GP-1:0][15:0] m_grid;
   logic [15:0]         m_scale;
   vec_t                vt[GP+1];
   logic                err_o;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Observes handshakes at the falling edge and scores them against the frame model.
   task automatic monitor();
      logic [2:0]       v, r, l;
      logic [2:0][15:0] d;
      frame_t           f;
      int               b;
      logic [15:0]      e;
      v = {m_axis_scale_tvalid, m_axis_grid_tvalid, m_axis_data_tvalid};
      r = {m_axis_scale_tready, m_axis_grid_tready, m_axis_data_tready};
      l = {m_axis_scale_tlast, m_axis_grid_tlast, m_axis_data_tlast};
      d = {m_axis_scale_tdata, m_axis_grid_tdata, m_axis_data_tdata};
      if (rst) begin
         pend = '0;
         return;
      end
      for (int k = 0; k < 3; k++) begin
         if (pend[k]) begin
            chk($sformatf("hold_valid_s%0d", k), 32'(v[k]), 32'd1);
            chk($sformatf("hold_data_s%0d", k), 32'(d[k]), 32'(pend_d[k]));
         end
         pend[k]   = v[k] && !r[k];
         pend_d[k] = d[k];
         if (v[k] && r[k]) begin
            chk($sformatf("beat_expected_s%0d", k), 32'(cnt[k] / GP < frames.size()), 32'd1);
            if (cnt[k] / GP < frames.size()) begin
               f = frames[cnt[k] / GP];
               b = cnt[k] % GP;
               e = (k == 0) ? f.x : (k == 1) ? f.grid[b] : f.scale;
               chk($sformatf("beat_data_s%0d_b%0d", k, b), 32'(d[k]), 32'(e));
               chk($sformatf("beat_last_s%0d_b%0d", k, b), 32'(l[k]), 32'(b == GP - 1));
               if (k == 0) chk($sformatf("beat_user_b%0d", b), 32'(m_axis_data_tuser), 32'(f.user));
            end
            cnt[k]++;
            tot_beats[k]++;
            if (l[k]) tot_last[k]++;
         end
      end
      if (s_axis_x_tvalid && s_axis_x_tready) begin
         f.x     = s_axis_x_tdata;
         f.user  = s_axis_x_tlast;
         f.scale = m_scale;
         f.grid  = m_grid;
         frames.push_back(f);
      end
   endtask

   task automatic step_to_neg();
      @(negedge clk);
      monitor();
   endtask

   task automatic step_to_pos();
      @(posedge clk);
      #1;
   endtask

   task automatic cycle();
      step_to_neg();
      step_to_pos();
   endtask

   task automatic model_reset();
      frames.delete();
      foreach (cnt[k]) cnt[k] = 0;
      m_grid  = '0;
      m_scale = 16'h1000;
   endtask

   task automatic cfg(input logic gwe, input logic [2:0] a, input logic [15:0] gd,
                      input logic swe, input logic [15:0] sd, output logic err);
      cfg_grid_we = gwe; cfg_grid_addr = a; cfg_grid_data = gd;
      cfg_scale_we = swe; cfg_scale_data = sd;
      cycle();
      cfg_grid_we = 1'b0; cfg_scale_we = 1'b0;
      step_to_neg();
      err = cfg_err;
      step_to_pos();
   endtask

   task automatic send_x(input logic [15:0] xv, input logic lst);
      logic done;
      done = 1'b0;
      s_axis_x_tvalid = 1'b1; s_axis_x_tdata = xv; s_axis_x_tlast = lst;
      for (int i = 0; i < 50 && !done; i++) begin
         step_to_neg();
         done = s_axis_x_tready;
         step_to_pos();
      end
      s_axis_x_tvalid = 1'b0; s_axis_x_tlast = 1'b0;
      chk("send_accept_timeout", 32'(done), 32'd1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(busy == 1'b0 && cnt[0] == frames.size() * GP && cnt[1] == frames.size() * GP &&
               cnt[2] == frames.size() * GP) && n < 500) begin
         cycle();
         n++;
      end
      chk("drain_timeout", 32'(n < 500), 32'd1);
   endtask

   task automatic all_ready(input logic val);
      m_axis_data_tready = val; m_axis_grid_tready = val; m_axis_scale_tready = val;
   endtask

   initial begin
      rst = 1'b1;
      cfg_grid_we = 1'b0; cfg_grid_addr = '0; cfg_grid_data = '0;
      cfg_scale_we = 1'b0; cfg_scale_data = '0;
      s_axis_x_tdata = '0; s_axis_x_tvalid = 1'b0; s_axis_x_tlast = 1'b0;
      all_ready(1'b1);
      pend = '0; pend_d = '0;
      foreach (tot_beats[k]) begin tot_beats[k] = 0; tot_last[k] = 0; end
      model_reset();
      for (int i = 0; i < GP; i++) vt[i] = '{1'b1, 16'(i << 12), (i == GP - 1), 1'b1, 1'b0};
      vt[GP] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};

      // reset state
      repeat (2) cycle();
      step_to_neg();
      chk("rst_valid", 32'({m_axis_scale_tvalid, m_axis_grid_tvalid, m_axis_data_tvalid}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cfg_err", 32'(cfg_err), 32'd0);
      chk("rst_tdata", 32'({m_axis_data_tdata, m_axis_grid_tdata}), 32'd0);
      chk("rst_tlast_tuser", 32'({m_axis_data_tlast, m_axis_data_tuser}), 32'd0);
      step_to_pos();
      rst = 1'b0;
      step_to_neg();
      chk("rst_sready", 32'(s_axis_x_tready), 32'd1);
      step_to_pos();

      // test 1: load table, one frame at full rate, cycle-by-cycle table
      for (int i = 0; i < GP; i++) begin
         cfg(1'b1, 3'(i), 16'(i << 12), 1'b0, 16'h0, err_o);
         chk("load_grid_err", 32'(err_o), 32'd0);
         m_grid[i] = 16'(i << 12);
      end
      cfg(1'b0, 3'd0, 16'h0, 1'b1, 16'h2000, err_o);
      chk("load_scale_err", 32'(err_o), 32'd0);
      m_scale = 16'h2000;
      send_x(16'h3000, 1'b0);
      for (int i = 0; i <= GP; i++) begin
         step_to_neg();
         chk($sformatf("t1_valid_r%0d", i),
             32'({m_axis_scale_tvalid, m_axis_grid_tvalid, m_axis_data_tvalid}), 32'({3{vt[i].valid}}));
         if (vt[i].valid) begin
            chk($sformatf("t1_grid_r%0d", i), 32'(m_axis_grid_tdata), 32'(vt[i].grid));
            chk($sformatf("t1_x_scale_r%0d", i), {m_axis_data_tdata, m_axis_scale_tdata}, 32'h3000_2000);
            chk($sformatf("t1_last_r%0d", i),
                32'({m_axis_scale_tlast, m_axis_grid_tlast, m_axis_data_tlast}), 32'({3{vt[i].last}}));
         end
         chk($sformatf("t1_busy_r%0d", i), 32'(busy), 32'(vt[i].busy));
         chk($sformatf("t1_sready_r%0d", i), 32'(s_axis_x_tready), 32'(vt[i].sready));
         step_to_pos();
      end
      wait_idle();

      // test 2: grid stream stalls on beat 2
      send_x(16'h3000, 1'b0);
      repeat (2) cycle();
      m_axis_grid_tready = 1'b0;
      for (int j = 0; j < 3; j++) begin
         step_to_neg();
         chk($sformatf("t2_data_valid_%0d", j), 32'({m_axis_scale_tvalid, m_axis_data_tvalid}),
             (j == 0) ? 32'd3 : 32'd0);
         chk($sformatf("t2_grid_valid_%0d", j), 32'(m_axis_grid_tvalid), 32'd1);
         chk($sformatf("t2_grid_hold_%0d", j), 32'(m_axis_grid_tdata), 32'h2000);
         step_to_pos();
      end
      m_axis_grid_tready = 1'b1;
      wait_idle();

      // test 3: random throttling, 100 samples
      foreach (tot_beats[k]) begin tot_beats[k] = 0; tot_last[k] = 0; end
      begin
         int base, n;
         base = frames.size();
         n = 0;
         while ((frames.size() - base < 100) && n < 20000) begin
            s_axis_x_tvalid    = ($urandom_range(0, 3) != 0);
            s_axis_x_tdata     = 16'($urandom);
            s_axis_x_tlast     = 1'($urandom);
            m_axis_data_tready = ($urandom_range(0, 3) != 0);
            m_axis_grid_tready = ($urandom_range(0, 3) != 0);
            m_axis_scale_tready = ($urandom_range(0, 3) != 0);
            cycle();
            n++;
         end
         chk("t3_accept_timeout", 32'(n < 20000), 32'd1);
         s_axis_x_tvalid = 1'b0; s_axis_x_tlast = 1'b0;
         n = 0;
         while (!(busy == 1'b0 && cnt[0] == frames.size() * GP && cnt[1] == frames.size() * GP &&
                  cnt[2] == frames.size() * GP) && n < 5000) begin
            m_axis_data_tready  = ($urandom_range(0, 3) != 0);
            m_axis_grid_tready  = ($urandom_range(0, 3) != 0);
            m_axis_scale_tready = ($urandom_range(0, 3) != 0);
            cycle();
            n++;
         end
         chk("t3_drain_timeout", 32'(n < 5000), 32'd1);
         all_ready(1'b1);
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("t3_beats_s%0d", k), 32'(tot_beats[k]), 32'd800);
            chk($sformatf("t3_tlast_s%0d", k), 32'(tot_last[k]), 32'd100);
         end
      end

      // test 4: config write rejected mid-frame and on the accept cycle, accepted when idle
      send_x(16'h0abc, 1'b0);
      repeat (3) cycle();
      cfg(1'b1, 3'd5, 16'h5555, 1'b0, 16'h0, err_o);
      chk("t4_run_err", 32'(err_o), 32'd1);
      step_to_neg();
      chk("t4_err_once", 32'(cfg_err), 32'd0);
      step_to_pos();
      wait_idle();
      s_axis_x_tvalid = 1'b1; s_axis_x_tdata = 16'h0def;
      cfg_grid_we = 1'b1; cfg_grid_addr = 3'd0; cfg_grid_data = 16'h7777;
      cycle();
      s_axis_x_tvalid = 1'b0; cfg_grid_we = 1'b0;
      step_to_neg();
      chk("t4_accept_cycle_err", 32'(cfg_err), 32'd1);
      step_to_pos();
      wait_idle();
      cfg(1'b1, 3'd5, 16'h5555, 1'b1, 16'h0c00, err_o);
      chk("t4_idle_err", 32'(err_o), 32'd0);
      m_grid[5] = 16'h5555;
      m_scale   = 16'h0c00;
      send_x(16'h0123, 1'b0);
      wait_idle();

      // test 5: tuser follows the latched s_tlast for one frame only
      send_x(16'h0aaa, 1'b1);
      step_to_neg();
      chk("t5_tuser_set", 32'(m_axis_data_tuser), 32'd1);
      step_to_pos();
      wait_idle();
      send_x(16'h0bbb, 1'b0);
      step_to_neg();
      chk("t5_tuser_clear", 32'(m_axis_data_tuser), 32'd0);
      step_to_pos();
      wait_idle();

      // test 6: reset at beat 4
      send_x(16'h4444, 1'b0);
      repeat (4) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      model_reset();
      step_to_neg();
      chk("t6_valid", 32'({m_axis_scale_tvalid, m_axis_grid_tvalid, m_axis_data_tvalid}), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_sready", 32'(s_axis_x_tready), 32'd1);
      step_to_pos();
      send_x(16'h1234, 1'b0);
      step_to_neg();
      chk("t6_grid_zero", 32'(m_axis_grid_tdata), 32'd0);
      chk("t6_scale_one", 32'(m_axis_scale_tdata), 32'h1000);
      step_to_pos();
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
